// File: rtl/raster_to_block.sv
// Raster-to-8x8 block reorder: buffers one 8-line band per bank and replays
// it as 8x8 blocks (row-major inside a block, blocks left to right).
module raster_to_block #(
    parameter int IMG_WIDTH = 64,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [BIT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    input  logic                 i_wait
);

    localparam int BAND   = 8 * IMG_WIDTH;
    localparam int AW     = $clog2(BAND);
    localparam int BLOCKS = IMG_WIDTH / 8;
    localparam int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StRead
    } state_e;

    logic [BIT_WIDTH-1:0] mem [2][BAND];

    logic [AW-1:0] waddr;
    logic          wbank;
    logic          rbank;
    logic          rbank_d;
    logic [1:0]    bank_full;
    logic [1:0]    full_d;

    state_e        state;
    logic [2:0]    col;
    logic [2:0]    row;
    logic [BW-1:0] blk;
    logic [AW-1:0] raddr;

    logic accept;
    logic wdone;
    logic issue;
    logic rdone;

    assign o_ready = !rst && !bank_full[wbank];
    assign accept  = i_valid && o_ready;
    assign wdone   = accept && (waddr == AW'(BAND - 1));

    assign issue = (state == StRead) && !i_wait;
    assign rdone = issue && (col == 3'd7) && (row == 3'd7) && (blk == BW'(BLOCKS - 1));
    assign raddr = AW'(row) * AW'(IMG_WIDTH) + AW'(blk) * AW'(8) + AW'(col);

    // Writer and reader always own different banks, so set and clear never collide.
    always_comb begin
        full_d = bank_full;
        if (wdone) full_d[wbank] = 1'b1;
        if (rdone) full_d[rbank] = 1'b0;
        rbank_d = rdone ? ~rbank : rbank;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wbank][waddr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr     <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            bank_full <= 2'b00;
        end else begin
            bank_full <= full_d;
            rbank     <= rbank_d;
            if (accept) waddr <= wdone ? '0 : waddr + AW'(1);
            if (wdone) wbank <= ~wbank;
        end
    end

    // Using the next-state flags lets the first read issue the cycle after the band completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            col     <= 3'd0;
            row     <= 3'd0;
            blk     <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                StIdle: if (full_d[rbank_d]) state <= StRead;
                StRead: if (rdone && !full_d[rbank_d]) state <= StIdle;
                default: state <= StIdle;
            endcase

            if (issue) begin
                if (col == 3'd7) begin
                    col <= 3'd0;
                    if (row == 3'd7) begin
                        row <= 3'd0;
                        blk <= (blk == BW'(BLOCKS - 1)) ? '0 : blk + BW'(1);
                    end else begin
                        row <= row + 3'd1;
                    end
                end else begin
                    col <= col + 3'd1;
                end
            end

            if (!i_wait) begin
                o_valid <= issue;
                o_last  <= issue && (col == 3'd7) && (row == 3'd7);
                if (issue) o_data <= mem[rbank][raddr];
            end
        end
    end

endmodule
